// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment pattern decoder.
// The glyph patterns are active-low {g,f,e,d,c,b,a}. Index n of GLYPH_TABLE
// is the pattern that displays hex digit n.
package sevenseg_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // All segments dark: a blank display, neither decoded nor flagged
    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t GLYPH_0 = 7'h40;
    localparam seg_t GLYPH_1 = 7'h79;
    localparam seg_t GLYPH_2 = 7'h24;
    localparam seg_t GLYPH_3 = 7'h30;
    localparam seg_t GLYPH_4 = 7'h19;
    localparam seg_t GLYPH_5 = 7'h12;
    localparam seg_t GLYPH_6 = 7'h02;
    localparam seg_t GLYPH_7 = 7'h78;
    localparam seg_t GLYPH_8 = 7'h00;
    localparam seg_t GLYPH_9 = 7'h10;
    localparam seg_t GLYPH_A = 7'h08;
    localparam seg_t GLYPH_B = 7'h03;
    localparam seg_t GLYPH_C = 7'h46;
    localparam seg_t GLYPH_D = 7'h21;
    localparam seg_t GLYPH_E = 7'h06;
    localparam seg_t GLYPH_F = 7'h0E;

    localparam seg_t GLYPH_TABLE [16] = '{
        GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3,
        GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
        GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B,
        GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
    };

    // SETTLE: waiting for a stable run; LOCKED: current run already handled
    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/sevenseg_lut.sv
// Combinational seven-segment pattern -> hex nibble lookup.
// Flags whether the pattern is a legal glyph or the blank pattern; the nibble
// is zero for anything that is not a legal glyph.
module sevenseg_lut
    import sevenseg_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic             o_legal,
    output logic             o_blank,
    output logic [3:0]       o_nibble
);

    logic [15:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign w_hit[gi] = (i_seg == GLYPH_TABLE[gi]);
        end
    endgenerate

    assign o_legal = |w_hit;
    assign o_blank = (i_seg == SEG_BLANK);

    // Encode the one-hot match vector into the nibble (glyphs are distinct)
    always_comb begin
        o_nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (w_hit[i]) begin
                o_nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sevenseg_decoder.sv
// Seven-segment pattern decoder with stability filter and valid/ready output.
// A pattern must be seen on STABLE_CYCLES consecutive compares before it is
// decoded once; illegal glyphs pulse err, dropped decodes pulse overrun.
// Optional feature: define SEVSEG_ERR_CNT_EN to build the saturating err_cnt
// counter; otherwise err_cnt is tied to zero.
module sevenseg_decoder
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] seg_in,
    output logic [3:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic             overrun,
    output logic [7:0]       err_cnt
);

    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

    seg_t       r_sample;
    logic [7:0] r_run;
    state_t     r_state;
    logic [3:0] r_out_data;
    logic       r_out_valid;
    logic       r_err;
    logic       r_overrun;

    logic       w_same;
    logic       w_decode;
    logic       w_legal;
    logic       w_blank;
    logic [3:0] w_nibble;
    logic       w_accept;
    logic       w_load;
    logic       w_drop;
    logic       w_illegal;

    // The stable pattern lives in r_sample, so only registered state feeds the LUT
    sevenseg_lut u_lut (
        .i_seg    (r_sample),
        .o_legal  (w_legal),
        .o_blank  (w_blank),
        .o_nibble (w_nibble)
    );

    assign w_same    = (seg_in == r_sample);
    assign w_decode  = (r_state == SETTLE) && (r_run == RUN_MAX);
    assign w_accept  = r_out_valid && out_ready;
    assign w_load    = w_decode && w_legal && (!r_out_valid || w_accept);
    assign w_drop    = w_decode && w_legal && r_out_valid && !out_ready;
    assign w_illegal = w_decode && !w_legal && !w_blank;

    // Input sampling, run-length counter and episode FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= SEG_BLANK;
            r_run    <= 8'd0;
            r_state  <= SETTLE;
        end else begin
            r_sample <= seg_in;
            if (!w_same) begin
                r_run   <= 8'd0;
                r_state <= SETTLE;
            end else begin
                if (r_run != RUN_MAX) begin
                    r_run <= r_run + 8'd1;
                end
                if (w_decode) begin
                    r_state <= LOCKED;
                end
            end
        end
    end

    // Output register with valid/ready handshake and single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= 4'h0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_err     <= w_illegal;
            r_overrun <= w_drop;
            if (w_load) begin
                r_out_data  <= w_nibble;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SEVSEG_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of illegal-glyph events, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_illegal && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Directed bench for sevenseg_decoder (STABLE_CYCLES=4). Expected output
// events are queued as stimulus is driven and matched as the DUT emits them.
module tb_sevenseg_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic       overrun;
    logic [7:0] err_cnt;

    sevenseg_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .overrun   (overrun),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

`ifdef SEVSEG_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [1:0] EV_DATA = 2'd0;
    localparam logic [1:0] EV_ERR  = 2'd1;
    localparam logic [1:0] EV_OVR  = 2'd2;

    localparam logic [6:0] G [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  exp_err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic note_event(input ev_t got);
        ev_t want;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_event observed=%0h expected=none", got);
        end
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("event", 32'(got), 32'(want));
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [3:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // One clock: handshake seen before the edge, pulses seen after it
    task automatic tick();
        logic       acc;
        logic [3:0] d;
        acc = out_valid && out_ready;
        d   = out_data;
        @(posedge clk);
        #1;
        if (acc)     note_event({EV_DATA, d});
        if (err)     note_event({EV_ERR, 4'h0});
        if (overrun) note_event({EV_OVR, 4'h0});
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        seg_in    = 7'h7F;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_data", 32'(out_data), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1;

        // Blank display: nothing decoded, nothing flagged
        hold(7'h7F, 10);
        chk("blank_valid", 32'(out_valid), 0);
        chk("blank_err", 32'(err), 0);

        // Decode latency: first present at edge E, valid at E+5 for one cycle
        push(EV_DATA, 4'h0);
        seg_in = 7'h40;
        repeat (5) tick();
        chk("lat_pre_valid", 32'(out_valid), 0);
        tick();
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 0);
        tick();
        chk("lat_post_valid", 32'(out_valid), 0);
        hold(7'h40, 20);
        chk("hold_no_redecode", 32'(exp_q.size()), 0);

        // Sweep every glyph
        hold(7'h7F, 2);
        for (int i = 0; i < 16; i++) begin
            push(EV_DATA, 4'(i));
            hold(G[i], 8);
        end
        chk("sweep_drain", 32'(exp_q.size()), 0);

        // Glitches: 2 and 4 cycles are filtered, 5 cycles is decoded
        push(EV_DATA, 4'h3);
        hold(7'h30, 8);
        hold(7'h79, 2);
        push(EV_DATA, 4'h3);
        hold(7'h30, 8);
        hold(7'h79, 4);
        push(EV_DATA, 4'h3);
        hold(7'h30, 8);
        push(EV_DATA, 4'h1);
        hold(7'h79, 5);
        push(EV_DATA, 4'h3);
        hold(7'h30, 8);
        chk("glitch_drain", 32'(exp_q.size()), 0);

        // Illegal pattern pulses err at E+5
        push(EV_ERR, 4'h0);
        seg_in = 7'h7E;
        repeat (5) tick();
        chk("ill_pre_err", 32'(err), 0);
        tick();
        if (CNT_EN) exp_err_cnt = 1;
        chk("ill_err", 32'(err), 1);
        chk("ill_valid", 32'(out_valid), 0);
        chk("ill_err_cnt1", 32'(err_cnt), 32'(exp_err_cnt));
        tick();
        chk("ill_err_pulse", 32'(err), 0);
        for (int k = 0; k < 299; k++) begin
            hold(7'h7F, 2);
            push(EV_ERR, 4'h0);
            hold(7'h7E, 6);
            if (CNT_EN && exp_err_cnt < 255) exp_err_cnt++;
        end
        chk("ill_err_cnt_sat", 32'(err_cnt), 32'(exp_err_cnt));

        // Overrun: 5 pending, 9 dropped
        hold(7'h7F, 2);
        out_ready = 1'b0;
        push(EV_OVR, 4'h0);
        push(EV_DATA, 4'h5);
        hold(7'h12, 8);
        chk("ovr_valid5", 32'(out_valid), 1);
        chk("ovr_data5", 32'(out_data), 5);
        seg_in = 7'h10;
        repeat (5) tick();
        tick();
        chk("ovr_pulse", 32'(overrun), 1);
        chk("ovr_keep_valid", 32'(out_valid), 1);
        chk("ovr_keep_data", 32'(out_data), 5);
        tick();
        chk("ovr_pulse_end", 32'(overrun), 0);
        tick();
        chk("ovr_hold_data", 32'(out_data), 5);
        out_ready = 1'b1;
        tick();
        chk("ovr_release", 32'(out_valid), 0);

        // Decode coinciding with acceptance loads without overrun
        hold(7'h7F, 2);
        out_ready = 1'b0;
        push(EV_DATA, 4'h2);
        push(EV_DATA, 4'h4);
        hold(7'h24, 8);
        seg_in = 7'h19;
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        chk("same_valid", 32'(out_valid), 1);
        chk("same_data", 32'(out_data), 4);
        chk("same_no_ovr", 32'(overrun), 0);
        tick();
        chk("same_clear", 32'(out_valid), 0);

        // Reset mid-episode discards progress; count restarts after release
        hold(7'h7F, 2);
        seg_in = 7'h12;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 0);
        tick();
        rst_n = 1'b1;
        push(EV_DATA, 4'h5);
        repeat (5) tick();
        chk("post_rst_pre", 32'(out_valid), 0);
        tick();
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_data", 32'(out_data), 5);
        tick();
        hold(7'h12, 4);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sevenseg_decoder.md
# sevenseg_decoder

- Recovers a 4-bit hex value from a 7-segment drive pattern.
- Inverse of the ALU's hex-to-seven-segment encoder.
- Filters the pattern until it has been stable for a configurable number of cycles, decodes it, and hands the nibble out over a valid/ready interface.
- Reports invalid patterns. Sits between a segment bus (ALU display output or a loop-back probe) and a consumer such as a self-checking harness or result register.

## Interface
- STABLE_CYCLES, default 4: consecutive identical samples required before decoding; legal range 2..255.
- clk  in  1: rising-edge clock.
- rst_n  in  1: reset, asynchronous, active-low.
- seg_in  in  7: segment pattern {g,f,e,d,c,b,a}, active-low (0 = segment lit).
- out_data  out  4: decoded hex nibble.
- out_valid  out  1: out_data holds a decoded value.
- out_ready  in  1: consumer accepts out_data.
- err  out  1: one-cycle pulse when a stable pattern is not a legal hex glyph.
- overrun  out  1: one-cycle pulse when a decode is dropped because out_valid is still pending.
- err_cnt  out  8: saturating count of err pulses (see Configuration).

## Operation
- Decode table (seg_in hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
- 7F (all segments off) is blank: it is never decoded and never flagged.
- Every other pattern is illegal.
- seg_in is registered into sample_q every cycle. A run counter tracks consecutive cycles where seg_in equals sample_q and saturates at STABLE_CYCLES.
- FSM has two states:
  - SETTLE: run counter counting.
    - On reaching STABLE_CYCLES, perform exactly one decode action and go to LOCKED.
    - Legal glyph: load out_data, set out_valid.
    - Blank: no action.
    - Illegal: pulse err.
  - LOCKED: episode already handled. Any change of seg_in resets the counter and returns to SETTLE.
- SETTLE with a changed seg_in restarts the count at 0.
- One decode per stable episode. The same glyph reappearing after a glitch is a new episode and is decoded again.
- Handshake:
  - out_valid stays high until a cycle with out_valid && out_ready. It clears on that edge.
  - out_data is held constant while out_valid is high.
- Decode while out_valid is pending and not being accepted that cycle: the new value is dropped, overrun pulses, and out_data/out_valid are unchanged.
- Decode in the same cycle as acceptance: the new value loads and out_valid stays high, with no overrun.
- Reset values: out_data=0, out_valid=0, err=0, overrun=0, err_cnt=0, sample_q=7F, counter=0, state=SETTLE.
- Reset asserted mid-episode discards all progress. A pending out_valid is lost.

## Timing
- A pattern first present at rising edge E produces its out_valid (or err) at edge E+STABLE_CYCLES+1 (registered outputs).
- Consumer sees out_valid at E+STABLE_CYCLES+1. If out_ready is high that cycle, out_valid is low after the next edge.
- A glitch shorter than STABLE_CYCLES cycles produces no decode and no err.
- err and overrun are single-cycle pulses, registered, coincident with the decode edge.
- No combinational path from seg_in or out_ready to any output.

## Configuration
- SEVSEG_ERR_CNT_EN defined: err_cnt increments on every err pulse and saturates at 255. It clears only on reset.
- SEVSEG_ERR_CNT_EN undefined: the counter logic is not compiled and err_cnt is tied to 0. The err pulse is unaffected.

## Structure
- Package sevenseg_pkg holds:
  - the 16 glyph constants and the blank constant (7F);
  - the state enum {SETTLE, LOCKED};
  - the segment-width localparam.
- Sub-module sevenseg_lut: combinational pattern -> {legal, blank, nibble}, built from the package constants. It is reusable by the harness as a reference model.

## Test plan (STABLE_CYCLES=4, out_ready=1 unless stated)
- Reset, then seg_in=7F for 10 cycles -> all outputs 0, no err.
- seg_in=40 from edge E -> out_valid=1, out_data=0 at edge E+5, for one cycle only. Holding 40 for 20 more cycles gives no further decode.
- Sweep all 16 glyphs, 8 cycles each -> out_data sequence 0..F, with one out_valid per glyph and no err.
- seg_in=79 for 2 cycles inside a run of 30 -> no decode of 1. The 30 pattern after the glitch decodes 3 again.
- seg_in=7E held 6 cycles -> err pulse at E+5, out_valid stays 0. With SEVSEG_ERR_CNT_EN, err_cnt=1; 300 such episodes give err_cnt=255.
- out_ready=0: glyph 5 then glyph 9, each held 8 cycles -> out_data stays 5 and overrun pulses once at 9's decode. Raising out_ready clears out_valid the next edge.
- Reset asserted 2 cycles into a stable 12 -> no decode. After release, the count restarts from 0 relative to the first post-reset edge.
